inst_issue_buffer: RTL

- Consumer end of the fetch-to-decode interface.
- Samples the 64-bit two-instruction bundle that fetch presents and drops NOP fill slots.
- Queues the remaining instructions in program order and issues one instruction per cycle to decode over a valid/ready handshake.
- Generates the interlock signal that stops fetch from advancing when the queue cannot absorb another full bundle.

---
 rtl/inst_issue_buffer.sv | 121 ++++++++++++
 1 files changed

// File: rtl/inst_issue_buffer.sv
// -----------------------------------------------------------------------------
// inst_issue_buffer
//
// Consumer end of the fetch-to-decode interface. Samples the two-instruction
// bundle presented by fetch, drops NOP fill slots, queues the remaining
// instructions in program order and issues one per cycle to decode over a
// valid/ready handshake. Drives an interlock back to fetch whenever the queue
// could not absorb another full bundle.
//
// Ports:
//   clk           clock
//   rstn          asynchronous active-low reset
//   fetch_bundle  [63:32] older instruction, [31:0] younger instruction
//   fetch_stall   stall seen by fetch; fetch holds its bundle while high
//   interlock     to fetch; fetch holds its bundle while high
//   flush         drop all queued instructions and the bundle of this cycle
//   issue_valid   issue_inst carries a valid instruction
//   issue_inst    head-of-queue instruction (NOP when empty)
//   issue_ready   decode accepts issue_inst at this edge
//   count         current occupancy
// -----------------------------------------------------------------------------
module inst_issue_buffer #(
    parameter int unsigned DEPTH = 4,
    parameter logic [31:0] NOP   = 32'hE000_0000
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [63:0]              fetch_bundle,
    input  logic                     fetch_stall,
    output logic                     interlock,
    input  logic                     flush,
    output logic                     issue_valid,
    output logic [31:0]              issue_inst,
    input  logic                     issue_ready,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [AW-1:0] yng_addr;
    logic [CW-1:0] count_q, count_d;
    logic          bundle_new_q;

    logic [31:0]   slot_old, slot_yng;
    logic          wr_old, wr_yng;
    logic [1:0]    n_in;
    logic          deq;
    logic [CW:0]   occ_in;

    // Enqueue decode, interlock and issue outputs.
    always_comb begin
        slot_old    = fetch_bundle[63:32];
        slot_yng    = fetch_bundle[31:0];
        // A bundle is only new in the cycle after fetch was allowed to advance;
        // otherwise it is a repeat of one already taken.
        wr_old      = bundle_new_q & ~flush & (slot_old != NOP);
        wr_yng      = bundle_new_q & ~flush & (slot_yng != NOP);
        n_in        = {1'b0, wr_old} + {1'b0, wr_yng};
        // Younger slot lands right behind the older one, or at tail if the
        // older slot was a NOP.
        yng_addr    = tail_q + AW'(wr_old);
        occ_in      = (CW+1)'(count_q) + (CW+1)'(n_in);
        // Dequeue is not credited: next occupancy stays <= DEPTH-2, so any
        // bundle admitted while interlock is low always fits.
        interlock   = ~flush & (occ_in > (CW+1)'(DEPTH - 2));
        issue_valid = (count_q != '0);
        issue_inst  = issue_valid ? mem_q[head_q] : NOP;
        deq         = issue_valid & issue_ready & ~flush;
        count       = count_q;
    end

    // Pointer and occupancy next state.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = tail_q;
            count_d = '0;
        end else begin
            if (deq) begin
                head_d = head_q + 1'b1;
            end
            tail_d  = tail_q + AW'(n_in);
            count_d = count_q + CW'(n_in) - CW'(deq);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            bundle_new_q <= 1'b0;
        end else begin
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            bundle_new_q <= ~fetch_stall & ~interlock;
        end
    end

    // Storage needs no reset: entries are only read when count is non-zero.
    always_ff @(posedge clk) begin
        if (wr_old) begin
            mem_q[tail_q] <= slot_old;
        end
        if (wr_yng) begin
            mem_q[yng_addr] <= slot_yng;
        end
    end

    // The interlock makes overflow unreachable; catch any design error.
    assert property (@(posedge clk) disable iff (!rstn) occ_in <= (CW+1)'(DEPTH))
        else $error("inst_issue_buffer overflow: count %0d + n_in %0d", count_q, n_in);

endmodule
